lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
// Load/store controller: checks a request, drives one data-memory cycle, returns formatted data or a fault.
// Latency 2 cycles for legal accesses, 1 for faults; req_ready only in IDLE; response held until resp_ready.
module lsu_ctrl #(
    parameter int MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [1:0]  mem_rwe,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [1:0]  mem_rwe_q, mem_rwe_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        code_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'b000:  v = {{24{rd[7]}}, rd[7:0]};
            3'b001:  v = {{16{rd[15]}}, rd[15:0]};
            3'b100:  v = {24'd0, rd[7:0]};
            3'b101:  v = {16'd0, rd[15:0]};
            default: v = rd;
        endcase
        return v;
    endfunction

    // Fault classification is purely a function of the request inputs.
    always_comb begin
        code_ok = 1'b0;
        if (req_we) begin
            code_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
                default:                                code_ok = 1'b0;
            endcase
        end

        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase

        out_of_range = (req_addr >= DEPTH_W);
        req_fault    = !code_ok || misaligned || out_of_range;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        mem_rwe_d    = mem_rwe_q;
        we_d         = we_q;
        funct3_d     = funct3_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    req_ready_d = 1'b0;
                    if (req_fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d    = EXEC;
                        mem_addr_d = req_addr;
                        if (req_we) begin
                            mem_wd_d  = req_wdata;
                            mem_rwe_d = req_funct3[1:0] + 2'd1;
                        end
                    end
                end
            end
            EXEC: begin
                // Memory bus returns to zero as the single access completes.
                state_d      = RESP;
                mem_addr_d   = 32'd0;
                mem_wd_d     = 32'd0;
                mem_rwe_d    = 2'd0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 32'd0 : fmt_load(funct3_q, mem_rd);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
                mem_addr_d   = 32'd0;
                mem_wd_d     = 32'd0;
                mem_rwe_d    = 2'd0;
            end
        endcase
    end

    // Asynchronous reset drops mem_rwe immediately, so an in-flight store never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wd_q     <= 32'd0;
            mem_rwe_q    <= 2'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_rwe_q    <= mem_rwe_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign mem_rwe    = mem_rwe_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
// Bench for lsu_ctrl: byte-addressed data memory, directed scenarios and a randomized run against a reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [1:0]  mem_rwe;
    logic [31:0] mem_rd;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] dev_mem [0:63];
    logic [7:0] ref_mem [0:63];

    int          wr_cnt = 0;
    int          exec_cnt = 0;
    int          spur_cnt = 0;
    logic [1:0]  wr_rwe_last = 2'd0;
    logic [31:0] wr_addr_last = 32'd0;
    logic [31:0] wr_wd_last = 32'd0;
    logic [31:0] exec_addr_last = 32'd0;

    lsu_ctrl #(.MEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rwe(mem_rwe), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Data memory: little-endian bytes starting at mem_addr, written at the rising edge.
    always_comb begin
        logic [32:0] idx;
        mem_rd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            idx = {1'b0, mem_addr} + 33'(i);
            if (idx < 33'd64) mem_rd[8*i +: 8] = dev_mem[idx[5:0]];
        end
    end

    always @(posedge clk) begin
        logic [32:0] wa;
        int nb;
        nb = (mem_rwe == 2'd1) ? 1 : (mem_rwe == 2'd2) ? 2 : (mem_rwe == 2'd3) ? 4 : 0;
        for (int k = 0; k < 4; k++) begin
            wa = {1'b0, mem_addr} + 33'(k);
            if (k < nb && wa < 33'd64) dev_mem[wa[5:0]] <= mem_wd[8*k +: 8];
        end
    end

    // Mid-cycle bus monitor; EXEC is the only state with req_ready and resp_valid both low.
    always @(negedge clk) begin
        if (mem_rwe != 2'd0) begin
            wr_cnt++;
            wr_rwe_last  = mem_rwe;
            wr_addr_last = mem_addr;
            wr_wd_last   = mem_wd;
        end
        if (!req_ready && !resp_valid) begin
            exec_cnt++;
            exec_addr_last = mem_addr;
        end
        if ((req_ready || resp_valid) && (mem_addr != 0 || mem_wd != 0 || mem_rwe != 0)) spur_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Reference behaviour computed from the access rules on a byte array.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output bit err, output logic [31:0] rd, output int lat, output int nwr);
        int size;
        bit legal;
        longint v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (a % size != 0) || (a >= 64);
        rd    = 32'd0;
        nwr   = 0;
        lat   = err ? 1 : 2;
        if (!err && we) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            nwr = 1;
        end
        if (!err && !we) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
            rd = v[31:0];
        end
    endtask

    task automatic drive_junk();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 2));
        req_addr   = 32'($urandom_range(0, 15)) * 32'd4;
        req_wdata  = $urandom;
    endtask

    // Issues one request now (caller is never on a rising edge) and follows it to IDLE.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input bit garble,
                          output int lat, output bit err, output logic [31:0] rd, output int nwr,
                          output int nexec, output bit stable, output bit idle_ok);
        int w0, e0;
        w0 = wr_cnt;
        e0 = exec_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        if (garble) drive_junk(); else req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (garble) drive_junk();
        end
        stable  = 1'b1;
        idle_ok = 1'b0;
        err     = resp_err;
        rd      = resp_rdata;
        if (!resp_valid) begin
            lat = -1;
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (garble) drive_junk();
                if (!resp_valid || req_ready || resp_err !== err || resp_rdata !== rd) stable = 1'b0;
            end
            @(negedge clk);
            resp_ready = 1'b1;
            @(posedge clk); #1;
            idle_ok    = (resp_valid === 1'b0) && (req_ready === 1'b1);
            resp_ready = 1'b0;
        end
        req_valid = 1'b0;
        nwr   = wr_cnt - w0;
        nexec = exec_cnt - e0;
    endtask

    int          g_lat, m_lat, g_nwr, m_nwr, g_nexec;
    bit          g_err, m_err, g_stable, g_idle;
    logic [31:0] g_rd, m_rd;

    task automatic test_reset();
        #12;
        n_vec++; if ({req_ready, resp_valid, resp_err} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got %b want 100", {req_ready, resp_valid, resp_err}); end
        n_vec++; if (resp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_vec++; if ({mem_addr, mem_wd, mem_rwe} !== 66'd0) begin n_err++; $display("FAIL reset_mem_bus: got %h/%h/%0d want 0", mem_addr, mem_wd, mem_rwe); end
        @(negedge clk);
        rst = 1'b1;
        model(1'b0, 3'b010, 32'd0, 32'd0, m_err, m_rd, m_lat, m_nwr);
        do_req(1'b0, 3'b010, 32'd0, 32'd0, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        n_vec++; if (g_lat !== 2) begin n_err++; $display("FAIL first_edge_accept_lat: got %0d want 2", g_lat); end
        n_vec++; if (g_rd !== m_rd || g_err !== 1'b0) begin n_err++; $display("FAIL first_edge_accept_resp: got %h/%b want %h/0", g_rd, g_err, m_rd); end
    endtask

    task automatic test_fill();
        logic [31:0] wd;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(1'b1, 3'b010, 32'(w * 4), wd, m_err, m_rd, m_lat, m_nwr);
            do_req(1'b1, 3'b010, 32'(w * 4), wd, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
            n_vec++; if (g_lat !== 2 || g_err !== 1'b0 || g_nwr !== 1 || g_idle !== 1'b1) begin n_err++; $display("FAIL fill_sw[%0d]: got lat %0d err %b wr %0d idle %b want 2 0 1 1", w, g_lat, g_err, g_nwr, g_idle); end
        end
    endtask

    task automatic test_round_trip();
        model(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, m_err, m_rd, m_lat, m_nwr);
        do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        n_vec++; if (g_lat !== 2) begin n_err++; $display("FAIL sw8_lat: got %0d want 2", g_lat); end
        n_vec++; if (g_err !== 1'b0 || g_rd !== 32'd0) begin n_err++; $display("FAIL sw8_resp: got %b/%h want 0/0", g_err, g_rd); end
        n_vec++; if (g_nwr !== 1 || wr_rwe_last !== 2'd3) begin n_err++; $display("FAIL sw8_rwe: got %0d cycles rwe %0d want 1 cycle rwe 3", g_nwr, wr_rwe_last); end
        n_vec++; if (wr_addr_last !== 32'd8 || wr_wd_last !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw8_bus: got %h/%h want 8/deadbeef", wr_addr_last, wr_wd_last); end
        do_req(1'b0, 3'b010, 32'd8, 32'd0, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        n_vec++; if (g_lat !== 2) begin n_err++; $display("FAIL lw8_lat: got %0d want 2", g_lat); end
        n_vec++; if (g_rd !== 32'hDEADBEEF || g_err !== 1'b0) begin n_err++; $display("FAIL lw8_resp: got %h/%b want deadbeef/0", g_rd, g_err); end
        n_vec++; if (g_nwr !== 0 || g_nexec !== 1 || exec_addr_last !== 32'd8) begin n_err++; $display("FAIL lw8_exec: got wr %0d exec %0d addr %h want 0 1 8", g_nwr, g_nexec, exec_addr_last); end
    endtask

    task automatic test_load_sign();
        logic [31:0] want [4];
        logic [2:0]  f3s  [4];
        logic [31:0] adr  [4];
        want = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001};
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
        adr  = '{32'd16, 32'd16, 32'd20, 32'd20};
        model(1'b1, 3'b010, 32'd16, 32'h000000F0, m_err, m_rd, m_lat, m_nwr);
        do_req(1'b1, 3'b010, 32'd16, 32'h000000F0, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        model(1'b1, 3'b010, 32'd20, 32'h00008001, m_err, m_rd, m_lat, m_nwr);
        do_req(1'b1, 3'b010, 32'd20, 32'h00008001, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adr[i], 32'd0, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
            n_vec++; if (g_rd !== want[i] || g_err !== 1'b0 || g_lat !== 2) begin n_err++; $display("FAIL load_sign[f3=%b]: got %h err %b lat %0d want %h 0 2", f3s[i], g_rd, g_err, g_lat, want[i]); end
        end
    endtask

    task automatic test_faults();
        bit          wes [4];
        logic [2:0]  f3s [4];
        logic [31:0] adr [4];
        wes = '{1'b0, 1'b1, 1'b0, 1'b0};
        f3s = '{3'b010, 3'b001, 3'b010, 3'b011};
        adr = '{32'd6, 32'd3, 32'd64, 32'd0};
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], f3s[i], adr[i], 32'hA5A5A5A5, 0, 1'b0, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
            n_vec++; if (g_lat !== 1) begin n_err++; $display("FAIL fault[%0d]_lat: got %0d want 1", i, g_lat); end
            n_vec++; if (g_err !== 1'b1 || g_rd !== 32'd0) begin n_err++; $display("FAIL fault[%0d]_resp: got %b/%h want 1/0", i, g_err, g_rd); end
            n_vec++; if (g_nwr !== 0 || g_nexec !== 0) begin n_err++; $display("FAIL fault[%0d]_no_access: got wr %0d exec %0d want 0 0", i, g_nwr, g_nexec); end
        end
    endtask

    task automatic test_backpressure();
        model(1'b0, 3'b010, 32'd12, 32'd0, m_err, m_rd, m_lat, m_nwr);
        do_req(1'b0, 3'b010, 32'd12, 32'd0, 5, 1'b1, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
        n_vec++; if (g_rd !== m_rd || g_err !== 1'b0) begin n_err++; $display("FAIL bp_resp: got %h/%b want %h/0", g_rd, g_err, m_rd); end
        n_vec++; if (g_stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", g_stable); end
        n_vec++; if (g_idle !== 1'b1) begin n_err++; $display("FAIL bp_release_idle: got %b want 1", g_idle); end
        n_vec++; if (g_nwr !== 0) begin n_err++; $display("FAIL bp_no_write: got %0d want 0", g_nwr); end
    endtask

    task automatic test_reset_mid_op();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd4; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++; if (mem_rwe !== 2'd3 || mem_addr !== 32'd4) begin n_err++; $display("FAIL rst_mid_exec: got rwe %0d addr %h want 3 4", mem_rwe, mem_addr); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_rwe} !== {3'b100, 98'd0}) begin n_err++; $display("FAIL rst_mid_outputs: got %b%b%b %h %h %h %0d want 100 all zero", req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_rwe); end
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_release: got ready %b valid %b want 1 0", req_ready, resp_valid); end
        n_vec++; if ({dev_mem[7], dev_mem[6], dev_mem[5], dev_mem[4]} !== {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}) begin n_err++; $display("FAIL rst_mid_word4: got %h want %h", {dev_mem[7], dev_mem[6], dev_mem[5], dev_mem[4]}, {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}); end
    endtask

    task automatic test_random();
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          r, size, bad;
        for (int n = 0; n < 150; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            r    = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 63)) & ~32'(size - 1);
            else if (r < 9) a = 32'($urandom_range(0, 63));
            else            a = 32'($urandom_range(60, 300));
            wd = $urandom;
            model(we, f3, a, wd, m_err, m_rd, m_lat, m_nwr);
            do_req(we, f3, a, wd, $urandom_range(0, 3), 1'b1, g_lat, g_err, g_rd, g_nwr, g_nexec, g_stable, g_idle);
            n_vec++; if (g_lat !== m_lat || g_err !== m_err || g_rd !== m_rd) begin n_err++; $display("FAIL rnd[%0d] we=%b f3=%b a=%h: got lat %0d err %b rd %h want %0d %b %h", n, we, f3, a, g_lat, g_err, g_rd, m_lat, m_err, m_rd); end
            n_vec++; if (g_nwr !== m_nwr || g_stable !== 1'b1 || g_idle !== 1'b1) begin n_err++; $display("FAIL rnd[%0d]_ctl: got wr %0d stable %b idle %b want %0d 1 1", n, g_nwr, g_stable, g_idle, m_nwr); end
            if (m_nwr == 1) begin
                n_vec++; if (wr_rwe_last !== 2'(f3 + 3'd1) || wr_addr_last !== a || wr_wd_last !== wd) begin n_err++; $display("FAIL rnd[%0d]_store_bus: got rwe %0d addr %h wd %h want %0d %h %h", n, wr_rwe_last, wr_addr_last, wr_wd_last, f3 + 3'd1, a, wd); end
            end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL final_memory: got %0d differing bytes want 0", bad); end
        n_vec++; if (spur_cnt !== 0) begin n_err++; $display("FAIL idle_bus_quiet: got %0d cycles with bus activity outside EXEC want 0", spur_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        test_reset();
        test_fill();
        test_round_trip();
        test_load_sign();
        test_faults();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
